// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: drives the interval timer, picks the lit mole from an
// LFSR, judges button hits and keeps score, lives and round count.
module mole_round_ctrl #(
  parameter int         NUM_MOLES      = 4,
  parameter int         ROUNDS         = 16,
  parameter int         LIVES          = 3,
  parameter int         START_INTERVAL = 5,
  parameter int         GAP_INTERVAL   = 1,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] btn,
  input  logic                 timeout,
  output logic                 timer_reset,
  output logic [2:0]           interval,
  output logic                 dir,
  output logic [NUM_MOLES-1:0] mole,
  output logic [7:0]           score,
  output logic [2:0]           lives,
  output logic [7:0]           round_cnt,
  output logic                 game_over,
  output logic                 busy
);

  localparam int         IW      = $clog2(NUM_MOLES);
  localparam logic [7:0] START8  = 8'(START_INTERVAL);
  localparam logic [2:0] GAP3    = 3'(GAP_INTERVAL);
  localparam logic [2:0] LIVES3  = 3'(LIVES);
  localparam logic [7:0] ROUNDS8 = 8'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_HIT, S_MISS, S_GAP, S_OVER
  } state_t;

  state_t               state, state_nxt;
  logic [7:0]           lfsr, lfsr_nxt;
  logic [IW-1:0]        idx, idx_nxt, cand;
  logic                 timer_reset_nxt, game_over_nxt, busy_nxt;
  logic [2:0]           interval_nxt, lives_nxt;
  logic [NUM_MOLES-1:0] mole_nxt;
  logic [7:0]           score_nxt, round_nxt;

  // Interval shrinks by one for every four points, never below 1.
  function automatic logic [2:0] difficulty(input logic [7:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s >> 2;
    d = START8 - q;
    if (q >= START8) return 3'd1;
    return d[2:0];
  endfunction

  assign dir  = 1'b0;
  assign cand = lfsr[IW-1:0];

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    idx_nxt   = idx;
    score_nxt = score;
    lives_nxt = lives;
    round_nxt = round_cnt;
    lfsr_nxt  = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_nxt = S_LOAD;
          score_nxt = 8'd0;
          lives_nxt = LIVES3;
          round_nxt = 8'd0;
        end
      end
      S_LOAD: begin
        // Never repeat the previous mole: step to the neighbour on a collision.
        idx_nxt   = (cand == idx) ? cand + IW'(1) : cand;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (btn != '0) begin
          state_nxt = (btn == mole) ? S_HIT : S_MISS;
        end else if (timeout) begin
          state_nxt = S_MISS;
        end
        if (state_nxt == S_HIT && score != 8'hFF) score_nxt = score + 8'd1;
        if (state_nxt == S_MISS) lives_nxt = lives - 3'd1;
      end
      S_HIT:  state_nxt = S_GAP;
      S_MISS: state_nxt = (lives == 3'd0) ? S_OVER : S_GAP;
      S_GAP: begin
        if (timeout) begin
          round_nxt = round_cnt + 8'd1;
          state_nxt = (round_nxt == ROUNDS8) ? S_OVER : S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    timer_reset_nxt = !(state_nxt == S_RUN || state_nxt == S_GAP);
    mole_nxt        = (state_nxt == S_RUN) ? ({{(NUM_MOLES-1){1'b0}}, 1'b1} << idx_nxt) : '0;
    game_over_nxt   = (state_nxt == S_OVER);
    busy_nxt        = !(state_nxt == S_IDLE || state_nxt == S_OVER);

    interval_nxt = interval;
    if (state_nxt == S_LOAD) interval_nxt = difficulty(score_nxt);
    if (state_nxt == S_HIT || (state_nxt == S_MISS && lives_nxt != 3'd0)) interval_nxt = GAP3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      idx         <= '0;
      timer_reset <= 1'b1;
      interval    <= 3'(START_INTERVAL);
      mole        <= '0;
      score       <= 8'd0;
      lives       <= LIVES3;
      round_cnt   <= 8'd0;
      game_over   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state       <= state_nxt;
      lfsr        <= lfsr_nxt;
      idx         <= idx_nxt;
      timer_reset <= timer_reset_nxt;
      interval    <= interval_nxt;
      mole        <= mole_nxt;
      score       <= score_nxt;
      lives       <= lives_nxt;
      round_cnt   <= round_nxt;
      game_over   <= game_over_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Self-checking bench for mole_round_ctrl: table-driven hit/miss judgements plus
// directed sequences for game over, a full 16-round game, start in OVER and reset.
module tb_mole_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, timeout;
  logic [3:0] btn;
  logic       timer_reset, dir, game_over, busy;
  logic [2:0] interval, lives;
  logic [3:0] mole;
  logic [7:0] score, round_cnt;

  mole_round_ctrl #(
    .NUM_MOLES(4), .ROUNDS(16), .LIVES(3),
    .START_INTERVAL(5), .GAP_INTERVAL(1), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .timeout(timeout),
    .timer_reset(timer_reset), .interval(interval), .dir(dir), .mole(mole),
    .score(score), .lives(lives), .round_cnt(round_cnt),
    .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, right-shifting Galois form, stepping every cycle.
  logic [7:0] m_lfsr;
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= lfsr_step(m_lfsr);

  int         m_prev = 0;
  logic [3:0] exp_mole;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [3:0] rot(input logic [3:0] m);
    return {m[2:0], m[3]};
  endfunction

  // Called at the negedge inside the LOAD cycle; leaves us at the first RUN negedge.
  task automatic in_load(input int exp_iv);
    int cand;
    check("load_treset", timer_reset, 1);
    check("load_interval", interval, exp_iv);
    check("load_busy", busy, 1);
    cand = int'(m_lfsr[1:0]);
    if (cand == m_prev) cand = (cand + 1) % 4;
    m_prev   = cand;
    exp_mole = 4'b0001 << cand;
    cyc();
    check("run_mole", mole, exp_mole);
    check("run_treset", timer_reset, 0);
  endtask

  // Apply one RUN-cycle stimulus, check the HIT/MISS cycle, then GAP or OVER.
  task automatic judge(input logic [3:0] b, input bit to, input int es, input int el);
    btn = b; timeout = to;
    cyc();
    btn = '0; timeout = 1'b0;
    check("hm_mole", mole, 0);
    check("hm_treset", timer_reset, 1);
    check("hm_score", score, es);
    check("hm_lives", lives, el);
    cyc();
    if (el == 0) begin
      check("over_flag", game_over, 1);
      check("over_busy", busy, 0);
      check("over_treset", timer_reset, 1);
    end else begin
      check("gap_treset", timer_reset, 0);
      check("gap_interval", interval, 1);
    end
  endtask

  // In GAP: a stray button is ignored, then the timeout ends the round.
  task automatic gap_timeout(input int exp_round, input bit last);
    btn = 4'hF;
    cyc();
    btn = '0;
    check("gap_btn_ignored", timer_reset, 0);
    timeout = 1'b1;
    cyc();
    timeout = 1'b0;
    check("round_cnt", round_cnt, exp_round);
    check("after_gap_over", game_over, last);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  typedef struct {
    int mode;      // 0 correct, 1 mole plus neighbour, 2 neighbour only, 3 none
    bit to;
    int wait_c;
    int exp_score;
    int exp_lives;
  } vec_t;

  vec_t vt[6];
  int   iv16[16];

  initial begin
    vt[0] = '{0, 1'b0, 3, 1, 3};
    vt[1] = '{1, 1'b0, 0, 1, 2};
    vt[2] = '{0, 1'b1, 1, 2, 2};
    vt[3] = '{2, 1'b0, 2, 2, 1};
    vt[4] = '{0, 1'b0, 0, 3, 1};
    vt[5] = '{3, 1'b1, 1, 3, 0};
    iv16  = '{5, 5, 5, 5, 4, 4, 4, 4, 3, 3, 3, 3, 2, 2, 2, 2};

    rst_n = 1'b0; start = 1'b0; btn = '0; timeout = 1'b0;
    #12;
    check("rst_treset", timer_reset, 1);
    check("rst_interval", interval, 5);
    check("rst_dir", dir, 0);
    check("rst_mole", mole, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives, 3);
    check("rst_round", round_cnt, 0);
    check("rst_over", game_over, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    cyc();

    // Timeout and buttons in IDLE do nothing.
    timeout = 1'b1; btn = 4'h1;
    cyc();
    timeout = 1'b0; btn = '0;
    cyc();
    check("idle_timeout_busy", busy, 0);
    check("idle_timeout_treset", timer_reset, 1);
    check("idle_lives", lives, 3);

    // Game A: table of judgements ending in game over.
    pulse_start();
    in_load(5);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] b;
      repeat (vt[i].wait_c) cyc();
      case (vt[i].mode)
        0:       b = exp_mole;
        1:       b = exp_mole | rot(exp_mole);
        2:       b = rot(exp_mole);
        default: b = 4'h0;
      endcase
      judge(b, vt[i].to, vt[i].exp_score, vt[i].exp_lives);
      if (vt[i].exp_lives != 0) begin
        gap_timeout(i + 1, 1'b0);
        in_load(5);
      end
    end
    repeat (3) cyc();
    check("over_hold_score", score, 3);
    check("over_hold_round", round_cnt, 5);
    check("over_hold_lives", lives, 0);
    check("over_hold_mole", mole, 0);

    // Start from OVER clears counters; RUN two cycles after start.
    pulse_start();
    check("restart_score", score, 0);
    check("restart_lives", lives, 3);
    check("restart_round", round_cnt, 0);
    check("restart_over", game_over, 0);
    in_load(5);

    // Start during RUN is ignored.
    pulse_start();
    check("run_start_mole", mole, exp_mole);
    check("run_start_treset", timer_reset, 0);

    // Never press: three timeouts drain the lives.
    judge(4'h0, 1'b1, 0, 2);
    gap_timeout(1, 1'b0);
    in_load(5);
    judge(4'h0, 1'b1, 0, 1);
    gap_timeout(2, 1'b0);
    in_load(5);
    judge(4'h0, 1'b1, 0, 0);
    check("nopress_score", score, 0);

    // Full game of 16 hits with shrinking intervals.
    pulse_start();
    for (int r = 0; r < 16; r++) begin
      in_load(iv16[r]);
      judge(exp_mole, 1'b0, r + 1, 3);
      gap_timeout(r + 1, r == 15);
    end
    check("full_score", score, 16);
    check("full_round", round_cnt, 16);
    check("full_busy", busy, 0);

    // Asynchronous reset in the middle of RUN.
    pulse_start();
    in_load(5);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check("arst_mole", mole, 0);
    check("arst_score", score, 0);
    check("arst_lives", lives, 3);
    check("arst_treset", timer_reset, 1);
    check("arst_busy", busy, 0);
    check("arst_interval", interval, 5);
    cyc();
    rst_n  = 1'b1;
    m_prev = 0;
    cyc();
    pulse_start();
    in_load(5);
    judge(exp_mole, 1'b0, 1, 3);
    gap_timeout(1, 1'b0);
    in_load(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
